// File: rtl/uart_rx.sv
// 8N1 UART receiver on the system clock: 2-flop synchronizer, internal baud
// counter, one-cycle done_rx / frame_err strobes.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to the start-bit centre to reject glitches
// DATA  | sampling 8 data bits LSB first at bit centres
// STOP  | sampling the stop bit at its centre
// BRK   | stop bit was low; wait for the line to return high
module uart_rx #(
   parameter int CLK_FRQ   = 100,
   parameter int BAUD_RATE = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       done_rx,
   output logic       frame_err,
   output logic       busy
);

   localparam int BAUD_COUNT = CLK_FRQ / BAUD_RATE;
   localparam int HALF       = BAUD_COUNT / 2;
   localparam int CW         = $clog2(BAUD_COUNT);

   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_COUNT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;
   logic          rx_s;

   assign rx_s   = sync_q[1];
   assign sync_d = {sync_q[0], rx};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  bit_idx_d = 3'd0;
                  state_d   = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               // last-bit exit decoded before the index could wrap
               if (bit_idx_q == 3'd7) state_d = STOP;
               else bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  rx_data_d = shift_q;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BRK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         BRK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sync_q    <= 2'b11;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         rx_data_q <= 8'h00;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign done_rx   = done_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule
